// File: rtl/writeback_buffer.sv
// Writeback buffer for dirty-line evictions.
// Holds evicted lines in a circular buffer, issues them to the bus arbiter
// strictly in allocation order, accepts out-of-order write acks, and retires
// completed entries from the head in order. Loads probe the buffer so that
// data still in flight is never missed.
//
// Entry states:
//   state   | meaning
//   --------+-------------------------------------------
//   FREE    | slot unused
//   PEND    | allocated, waiting to be issued to arbiter
//   INFL    | issued, waiting for the bus write ack
//   DONE    | acked, waiting to retire from head
module writeback_buffer #(
    parameter  int DEPTH     = 8,
    parameter  int LINE_BITS = 512,
    parameter  int PADDR_W   = 40,
    localparam int ID_W      = $clog2(DEPTH),
    localparam int OFF_W     = $clog2(LINE_BITS / 8)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enq_valid,
    output logic                 enq_ready,
    input  logic [PADDR_W-1:0]   enq_paddr,
    input  logic [LINE_BITS-1:0] enq_data,
    output logic                 wbq2arb_valid,
    input  logic                 wbq2arb_ready,
    output logic [PADDR_W-1:0]   wbq2arb_paddr,
    output logic [LINE_BITS-1:0] wbq2arb_data,
    output logic [ID_W-1:0]      wbq2arb_wbqid,
    input  logic                 arb2wbq_ack_valid,
    input  logic [ID_W-1:0]      arb2wbq_ack_wbqid,
    input  logic [PADDR_W-1:0]   lkup_paddr,
    output logic                 lkup_hit,
    output logic [LINE_BITS-1:0] lkup_data,
    output logic                 wbq_empty,
    output logic [ID_W:0]        wbq_count
);

    localparam int LA_W = PADDR_W - OFF_W;

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_PEND = 2'd1,
        ST_INFL = 2'd2,
        ST_DONE = 2'd3
    } ent_st_e;

    ent_st_e              st_q   [DEPTH];
    ent_st_e              st_d   [DEPTH];
    logic [LA_W-1:0]      la_q   [DEPTH];
    logic [LA_W-1:0]      la_d   [DEPTH];
    logic [LINE_BITS-1:0] data_q [DEPTH];
    logic [LINE_BITS-1:0] data_d [DEPTH];

    logic [ID_W:0]   head_q, head_d;
    logic [ID_W:0]   iss_q,  iss_d;
    logic [ID_W:0]   tail_q, tail_d;

    logic [ID_W-1:0] head_idx, iss_idx, tail_idx;
    logic [LA_W-1:0] enq_la, lk_la;
    logic            full;
    logic            issue_valid;
    logic            fire;
    logic            coal_hit;
    logic [ID_W-1:0] coal_idx;
    logic            alloc;
    logic [ID_W-1:0] lk_idx;
    logic            unused_off;

    // Offset bits address bytes within a line and never take part in compares.
    assign unused_off = ^{enq_paddr[OFF_W-1:0], lkup_paddr[OFF_W-1:0]};

    assign head_idx = head_q[ID_W-1:0];
    assign iss_idx  = iss_q[ID_W-1:0];
    assign tail_idx = tail_q[ID_W-1:0];
    assign enq_la   = enq_paddr[PADDR_W-1:OFF_W];
    assign lk_la    = lkup_paddr[PADDR_W-1:OFF_W];

    assign wbq_count   = tail_q - head_q;
    assign full        = (wbq_count == (ID_W+1)'(DEPTH));
    assign wbq_empty   = (wbq_count == '0);
    assign issue_valid = (st_q[iss_idx] == ST_PEND);
    assign fire        = issue_valid & wbq2arb_ready;

    // A pending entry that is issuing this cycle can no longer absorb new data.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_valid && st_q[i] == ST_PEND && la_q[i] == enq_la &&
                !(fire && ID_W'(i) == iss_idx)) begin
                coal_hit = 1'b1;
                coal_idx = ID_W'(i);
            end
        end
    end

    // Fullness uses pre-retire occupancy, so a slot freed this cycle is not reused yet.
    assign enq_ready = ~full | coal_hit;
    assign alloc     = enq_valid & ~coal_hit & ~full;

    assign wbq2arb_valid = issue_valid;
    assign wbq2arb_paddr = issue_valid ? {la_q[iss_idx], {OFF_W{1'b0}}} : '0;
    assign wbq2arb_data  = issue_valid ? data_q[iss_idx] : '0;
    assign wbq2arb_wbqid = issue_valid ? iss_idx : '0;

    // Next state: coalesce/allocate, issue, ack and retire all land together.
    always_comb begin
        st_d   = st_q;
        la_d   = la_q;
        data_d = data_q;
        head_d = head_q;
        iss_d  = iss_q;
        tail_d = tail_q;

        if (coal_hit) begin
            data_d[coal_idx] = enq_data;
        end else if (alloc) begin
            st_d[tail_idx]   = ST_PEND;
            la_d[tail_idx]   = enq_la;
            data_d[tail_idx] = enq_data;
            tail_d           = tail_q + (ID_W+1)'(1);
        end

        if (fire) begin
            st_d[iss_idx] = ST_INFL;
            iss_d         = iss_q + (ID_W+1)'(1);
        end

        if (arb2wbq_ack_valid && st_q[arb2wbq_ack_wbqid] == ST_INFL) begin
            st_d[arb2wbq_ack_wbqid] = ST_DONE;
        end

        if (st_q[head_idx] == ST_DONE) begin
            st_d[head_idx] = ST_FREE;
            head_d         = head_q + (ID_W+1)'(1);
        end
    end

    // Lookup scans oldest to youngest so the youngest match overrides.
    always_comb begin
        lkup_hit  = 1'b0;
        lkup_data = '0;
        lk_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lk_idx = head_idx + ID_W'(k);
            if (st_q[lk_idx] != ST_FREE && la_q[lk_idx] == lk_la) begin
                lkup_hit  = 1'b1;
                lkup_data = data_q[lk_idx];
            end
        end
    end

    // Entry states and pointers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i] <= ST_FREE;
            end
            head_q <= '0;
            iss_q  <= '0;
            tail_q <= '0;
        end else begin
            st_q   <= st_d;
            head_q <= head_d;
            iss_q  <= iss_d;
            tail_q <= tail_d;
        end
    end

    // Address and data storage; only meaningful while the entry is live.
    always_ff @(posedge clock) begin
        la_q   <= la_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed testbench for writeback_buffer at default parameters.
module tb_writeback_buffer;

    localparam int DEPTH = 8;
    localparam int LB    = 512;
    localparam int PW    = 40;
    localparam int IW    = 3;

    localparam logic [LB-1:0] DA = {16{32'hAAAA_0001}};
    localparam logic [LB-1:0] DB = {16{32'hBBBB_0002}};
    localparam logic [LB-1:0] D1 = {16{32'h1111_0001}};
    localparam logic [LB-1:0] D2 = {16{32'h2222_0002}};
    localparam logic [LB-1:0] DE = {16{32'hEEEE_000E}};

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enq_valid;
    logic          enq_ready;
    logic [PW-1:0] enq_paddr;
    logic [LB-1:0] enq_data;
    logic          wbq2arb_valid;
    logic          wbq2arb_ready;
    logic [PW-1:0] wbq2arb_paddr;
    logic [LB-1:0] wbq2arb_data;
    logic [IW-1:0] wbq2arb_wbqid;
    logic          ack_valid;
    logic [IW-1:0] ack_wbqid;
    logic [PW-1:0] lkup_paddr;
    logic          lkup_hit;
    logic [LB-1:0] lkup_data;
    logic          wbq_empty;
    logic [IW:0]   wbq_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    writeback_buffer #(.DEPTH(DEPTH), .LINE_BITS(LB), .PADDR_W(PW)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .enq_valid         (enq_valid),
        .enq_ready         (enq_ready),
        .enq_paddr         (enq_paddr),
        .enq_data          (enq_data),
        .wbq2arb_valid     (wbq2arb_valid),
        .wbq2arb_ready     (wbq2arb_ready),
        .wbq2arb_paddr     (wbq2arb_paddr),
        .wbq2arb_data      (wbq2arb_data),
        .wbq2arb_wbqid     (wbq2arb_wbqid),
        .arb2wbq_ack_valid (ack_valid),
        .arb2wbq_ack_wbqid (ack_wbqid),
        .lkup_paddr        (lkup_paddr),
        .lkup_hit          (lkup_hit),
        .lkup_data         (lkup_data),
        .wbq_empty         (wbq_empty),
        .wbq_count         (wbq_count)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid     = 1'b0;
        enq_paddr     = '0;
        enq_data      = '0;
        wbq2arb_ready = 1'b0;
        ack_valid     = 1'b0;
        ack_wbqid     = '0;
        lkup_paddr    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    function automatic logic [LB-1:0] fill_data(input int i);
        logic [31:0] w;
        w = 32'hF000_0000 | 32'(i);
        return {16{w}};
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        checks++; if (wbq2arb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", wbq2arb_valid); end
        checks++; if (lkup_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", lkup_hit); end
        checks++; if (wbq_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", wbq_empty); end
        checks++; if (wbq_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", wbq_count); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
        checks++; if (wbq2arb_data !== '0) begin errors++; $display("FAIL reset_arb_data: got %h expected 0", wbq2arb_data[31:0]); end
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_issue_order();
        do_reset();
        wbq2arb_ready = 1'b1;
        enq_valid = 1'b1; enq_paddr = 40'h1000; enq_data = DA;
        step();
        enq_paddr = 40'h2040; enq_data = DB;
        #1;
        checks++; if (wbq2arb_valid !== 1'b1) begin errors++; $display("FAIL order_a_valid: got %b expected 1", wbq2arb_valid); end
        checks++; if (wbq2arb_wbqid !== 3'd0) begin errors++; $display("FAIL order_a_id: got %0d expected 0", wbq2arb_wbqid); end
        checks++; if (wbq2arb_paddr !== 40'h1000) begin errors++; $display("FAIL order_a_paddr: got %h expected 1000", wbq2arb_paddr); end
        checks++; if (wbq2arb_data !== DA) begin errors++; $display("FAIL order_a_data: got %h expected %h", wbq2arb_data[31:0], DA[31:0]); end
        step();
        enq_valid = 1'b0;
        #1;
        checks++; if (wbq2arb_valid !== 1'b1) begin errors++; $display("FAIL order_b_valid: got %b expected 1", wbq2arb_valid); end
        checks++; if (wbq2arb_wbqid !== 3'd1) begin errors++; $display("FAIL order_b_id: got %0d expected 1", wbq2arb_wbqid); end
        checks++; if (wbq2arb_paddr !== 40'h2040) begin errors++; $display("FAIL order_b_paddr: got %h expected 2040", wbq2arb_paddr); end
        checks++; if (wbq2arb_data !== DB) begin errors++; $display("FAIL order_b_data: got %h expected %h", wbq2arb_data[31:0], DB[31:0]); end
        checks++; if (wbq_count !== 4'd2) begin errors++; $display("FAIL order_count: got %0d expected 2", wbq_count); end
        step();
        #1;
        checks++; if (wbq2arb_valid !== 1'b0) begin errors++; $display("FAIL order_drained: got %b expected 0", wbq2arb_valid); end
        checks++; if (wbq2arb_data !== '0) begin errors++; $display("FAIL order_data_zero: got %h expected 0", wbq2arb_data[31:0]); end
        checks++; if (wbq_count !== 4'd2) begin errors++; $display("FAIL order_count_after: got %0d expected 2", wbq_count); end
    endtask

    task automatic test_coalesce();
        do_reset();
        wbq2arb_ready = 1'b0;
        enq_valid = 1'b1; enq_paddr = 40'h1000; enq_data = D1;
        step();
        enq_data = D2;
        #1;
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL coal_ready: got %b expected 1", enq_ready); end
        step();
        enq_valid = 1'b0;
        #1;
        checks++; if (wbq_count !== 4'd1) begin errors++; $display("FAIL coal_count: got %0d expected 1", wbq_count); end
        checks++; if (wbq2arb_data !== D2) begin errors++; $display("FAIL coal_data: got %h expected %h", wbq2arb_data[31:0], D2[31:0]); end
        checks++; if (wbq2arb_wbqid !== 3'd0) begin errors++; $display("FAIL coal_id: got %0d expected 0", wbq2arb_wbqid); end
        wbq2arb_ready = 1'b1;
        step();
        wbq2arb_ready = 1'b0;
        #1;
        checks++; if (wbq2arb_valid !== 1'b0) begin errors++; $display("FAIL coal_issued_once: got %b expected 0", wbq2arb_valid); end
    endtask

    task automatic test_coalesce_firing();
        do_reset();
        enq_valid = 1'b1; enq_paddr = 40'h5000; enq_data = D1;
        step();
        wbq2arb_ready = 1'b1;
        enq_data = D2;
        #1;
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL fire_enq_ready: got %b expected 1", enq_ready); end
        step();
        enq_valid = 1'b0;
        wbq2arb_ready = 1'b0;
        #1;
        checks++; if (wbq_count !== 4'd2) begin errors++; $display("FAIL fire_count: got %0d expected 2", wbq_count); end
        checks++; if (wbq2arb_wbqid !== 3'd1) begin errors++; $display("FAIL fire_id: got %0d expected 1", wbq2arb_wbqid); end
        checks++; if (wbq2arb_data !== D2) begin errors++; $display("FAIL fire_data: got %h expected %h", wbq2arb_data[31:0], D2[31:0]); end
    endtask

    task automatic test_fill();
        logic [LB-1:0] exp_d;
        do_reset();
        wbq2arb_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            enq_valid = 1'b1;
            enq_paddr = 40'h10000 + 40'(i) * 40'h40;
            enq_data  = fill_data(i);
            step();
        end
        enq_valid = 1'b0;
        #1;
        checks++; if (wbq_count !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d expected 8", wbq_count); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", enq_ready); end
        enq_valid = 1'b1; enq_paddr = 40'h9000; enq_data = D1;
        #1;
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_new: got %b expected 0", enq_ready); end
        enq_paddr = 40'h10140; enq_data = DE;
        #1;
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_coal: got %b expected 1", enq_ready); end
        step();
        enq_valid = 1'b0;
        lkup_paddr = 40'h10143;
        #1;
        checks++; if (wbq_count !== 4'd8) begin errors++; $display("FAIL fill_count_coal: got %0d expected 8", wbq_count); end
        checks++; if (lkup_hit !== 1'b1 || lkup_data !== DE) begin errors++; $display("FAIL fill_lookup: got hit %b data %h expected hit 1 data %h", lkup_hit, lkup_data[31:0], DE[31:0]); end
        wbq2arb_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_d = (i == 5) ? DE : fill_data(i);
            #1;
            checks++; if (wbq2arb_valid !== 1'b1 || wbq2arb_wbqid !== 3'(i) || wbq2arb_data !== exp_d) begin errors++; $display("FAIL fill_issue: got valid %b id %0d data %h expected valid 1 id %0d data %h", wbq2arb_valid, wbq2arb_wbqid, wbq2arb_data[31:0], i, exp_d[31:0]); end
            step();
        end
        wbq2arb_ready = 1'b0;
        #1;
        checks++; if (wbq2arb_valid !== 1'b0) begin errors++; $display("FAIL fill_all_issued: got %b expected 0", wbq2arb_valid); end
        ack_valid = 1'b1; ack_wbqid = 3'd3;
        step();
        ack_valid = 1'b0;
        step();
        #1;
        checks++; if (wbq_count !== 4'd8) begin errors++; $display("FAIL ack3_no_retire: got %0d expected 8", wbq_count); end
        ack_valid = 1'b1; ack_wbqid = 3'd0;
        step();
        ack_valid = 1'b0;
        enq_valid = 1'b1; enq_paddr = 40'h9000; enq_data = D1;
        #1;
        checks++; if (wbq_count !== 4'd8) begin errors++; $display("FAIL ack0_same_cycle: got %0d expected 8", wbq_count); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_retire_ready: got %b expected 0", enq_ready); end
        step();
        enq_valid = 1'b0;
        lkup_paddr = 40'h9000;
        #1;
        checks++; if (wbq_count !== 4'd7) begin errors++; $display("FAIL ack0_retired: got %0d expected 7", wbq_count); end
        checks++; if (lkup_hit !== 1'b0 || lkup_data !== '0) begin errors++; $display("FAIL no_bypass: got hit %b data %h expected hit 0 data 0", lkup_hit, lkup_data[31:0]); end
        ack_valid = 1'b1; ack_wbqid = 3'd1;
        step();
        ack_wbqid = 3'd2;
        #1;
        checks++; if (wbq_count !== 4'd7) begin errors++; $display("FAIL ack1_same_cycle: got %0d expected 7", wbq_count); end
        step();
        ack_valid = 1'b0;
        #1;
        checks++; if (wbq_count !== 4'd6) begin errors++; $display("FAIL retire1: got %0d expected 6", wbq_count); end
        step();
        #1;
        checks++; if (wbq_count !== 4'd5) begin errors++; $display("FAIL retire2: got %0d expected 5", wbq_count); end
        step();
        #1;
        checks++; if (wbq_count !== 4'd4) begin errors++; $display("FAIL retire3: got %0d expected 4", wbq_count); end
        step();
        #1;
        checks++; if (wbq_count !== 4'd4) begin errors++; $display("FAIL retire_stop: got %0d expected 4", wbq_count); end
        ack_valid = 1'b1; ack_wbqid = 3'd0;
        step();
        ack_valid = 1'b0;
        step();
        #1;
        checks++; if (wbq_count !== 4'd4) begin errors++; $display("FAIL ack_free_ignored: got %0d expected 4", wbq_count); end
        lkup_paddr = '0;
    endtask

    task automatic test_infl_realloc();
        do_reset();
        wbq2arb_ready = 1'b1;
        enq_valid = 1'b1; enq_paddr = 40'h3000; enq_data = DA;
        step();
        enq_valid = 1'b0;
        step();
        wbq2arb_ready = 1'b0;
        enq_valid = 1'b1; enq_paddr = 40'h3000; enq_data = DB;
        #1;
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL infl_ready: got %b expected 1", enq_ready); end
        step();
        enq_valid = 1'b0;
        lkup_paddr = 40'h3010;
        #1;
        checks++; if (wbq_count !== 4'd2) begin errors++; $display("FAIL infl_count: got %0d expected 2", wbq_count); end
        checks++; if (lkup_hit !== 1'b1) begin errors++; $display("FAIL infl_hit: got %b expected 1", lkup_hit); end
        checks++; if (lkup_data !== DB) begin errors++; $display("FAIL infl_youngest: got %h expected %h", lkup_data[31:0], DB[31:0]); end
        checks++; if (wbq2arb_valid !== 1'b1 || wbq2arb_wbqid !== 3'd1) begin errors++; $display("FAIL infl_issue: got valid %b id %0d expected valid 1 id 1", wbq2arb_valid, wbq2arb_wbqid); end
        lkup_paddr = 40'h4000;
        #1;
        checks++; if (lkup_hit !== 1'b0 || lkup_data !== '0) begin errors++; $display("FAIL lookup_miss: got hit %b data %h expected hit 0 data 0", lkup_hit, lkup_data[31:0]); end
        lkup_paddr = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            enq_valid = 1'b1;
            enq_paddr = 40'h20000 + 40'(i) * 40'h40;
            enq_data  = fill_data(i + 16);
            step();
        end
        enq_valid = 1'b0;
        wbq2arb_ready = 1'b1;
        step();
        step();
        step();
        wbq2arb_ready = 1'b0;
        #1;
        checks++; if (wbq_count !== 4'd5 || wbq2arb_valid !== 1'b1) begin errors++; $display("FAIL mid_setup: got count %0d valid %b expected count 5 valid 1", wbq_count, wbq2arb_valid); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (wbq2arb_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", wbq2arb_valid); end
        checks++; if (wbq_empty !== 1'b1 || wbq_count !== 4'd0) begin errors++; $display("FAIL mid_empty: got empty %b count %0d expected empty 1 count 0", wbq_empty, wbq_count); end
        step();
        reset_n = 1'b1;
        ack_valid = 1'b1; ack_wbqid = 3'd2;
        step();
        ack_valid = 1'b0;
        step();
        #1;
        checks++; if (wbq_count !== 4'd0 || wbq_empty !== 1'b1 || wbq2arb_valid !== 1'b0) begin errors++; $display("FAIL mid_ack_ignored: got count %0d empty %b valid %b expected 0 1 0", wbq_count, wbq_empty, wbq2arb_valid); end
    endtask

    task automatic test_wrap();
        logic [PW-1:0] exp_pa;
        logic [LB-1:0] exp_d;
        do_reset();
        wbq2arb_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            exp_pa = 40'h40000 + 40'(n) * 40'h40;
            exp_d  = fill_data(n + 100);
            enq_valid = 1'b1; enq_paddr = exp_pa; enq_data = exp_d;
            step();
            enq_valid = 1'b0;
            #1;
            checks++; if (wbq2arb_valid !== 1'b1 || wbq2arb_wbqid !== 3'(n % 8) || wbq2arb_paddr !== exp_pa || wbq2arb_data !== exp_d) begin errors++; $display("FAIL wrap_issue[%0d]: got valid %b id %0d paddr %h expected valid 1 id %0d paddr %h", n, wbq2arb_valid, wbq2arb_wbqid, wbq2arb_paddr, n % 8, exp_pa); end
            step();
            #1;
            checks++; if (wbq2arb_valid !== 1'b0) begin errors++; $display("FAIL wrap_dup[%0d]: got valid %b expected 0", n, wbq2arb_valid); end
            ack_valid = 1'b1; ack_wbqid = 3'(n % 8);
            step();
            ack_valid = 1'b0;
            step();
            #1;
            checks++; if (wbq_count !== 4'd0 || wbq_empty !== 1'b1) begin errors++; $display("FAIL wrap_retire[%0d]: got count %0d empty %b expected 0 1", n, wbq_count, wbq_empty); end
        end
        wbq2arb_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_issue_order();
        test_coalesce();
        test_coalesce_firing();
        test_fill();
        test_infl_realloc();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 Parameters SHALL be:
- DEPTH, default 8: number of entries; power of 2, at least 2.
- LINE_BITS, default 512: cache-line data width.
- PADDR_W, default `PADDR_RANGE width: physical address width.
- ID_W = log2(DEPTH): entry-id width, matching `MSHR_NUM_LOG at defaults.
- OFF_W = log2(LINE_BITS/8): line-offset bits, excluded from all address compares.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1: single clock.
- reset_n, in, 1: asynchronous, active-low reset.
- enq_valid, in, 1: dirty-line eviction request.
- enq_ready, out, 1: eviction accepted.
- enq_paddr, in, PADDR_W: evicted line address.
- enq_data, in, LINE_BITS: evicted line data.
- wbq2arb_valid, out, 1: write request to the arbiter.
- wbq2arb_ready, in, 1: arbiter accepts the request.
- wbq2arb_paddr, out, PADDR_W: request address, offset bits zero.
- wbq2arb_data, out, LINE_BITS: request data.
- wbq2arb_wbqid, out, ID_W: entry index of the request.
- arb2wbq_ack_valid, in, 1: bus write-completion.
- arb2wbq_ack_wbqid, in, ID_W: entry index being completed.
- lkup_paddr, in, PADDR_W: load probe address.
- lkup_hit, out, 1: probe matches a live entry.
- lkup_data, out, LINE_BITS: line data for the probe hit.
- wbq_empty, out, 1: no live entries.
- wbq_count, out, ID_W+1: number of live entries.

Function
REQ-003 Each entry SHALL hold one state: FREE, PEND (allocated, not issued), INFL (issued, awaiting ack) or DONE (acked, awaiting retire).
REQ-004 Storage SHALL be a circular buffer with three ID_W+1-bit pointers: head (oldest), iss (next to issue) and tail (next free). All three wrap modulo DEPTH; the MSB distinguishes full from empty.
REQ-005 Occupancy SHALL be defined as:
- wbq_count = tail - head.
- full when wbq_count == DEPTH.
- wbq_empty when wbq_count == 0.
REQ-006 Coalesce: if enq_valid is high and enq_paddr[PADDR_W-1:OFF_W] matches a PEND entry that is not firing on wbq2arb this cycle, that entry's data SHALL be overwritten, with no allocation.
REQ-007 Allocate: otherwise, if not full, enq_valid SHALL write the entry at tail, mark it PEND, and increment tail.
REQ-008 enq_ready SHALL be combinational: (not full) OR (coalesce match per REQ-006).
REQ-009 Issue: wbq2arb_valid SHALL be 1 when entry[iss] is PEND, driving that entry's paddr, data and wbqid = iss[ID_W-1:0]. Issues SHALL be strictly in allocation order.
REQ-010 When wbq2arb_valid and wbq2arb_ready are both 1, entry[iss] SHALL become INFL and iss SHALL increment. Payload SHALL stay stable while valid is high and ready is low.
REQ-011 Ack: arb2wbq_ack_valid with an INFL id SHALL set that entry DONE. Acks may arrive in any order. An ack to a non-INFL entry SHALL be ignored (no state change).
REQ-012 Retire: when entry[head] is DONE, it SHALL become FREE and head SHALL increment, at most one per cycle, in the cycle after its ack at the earliest.
REQ-013 Lookup SHALL be combinational over PEND, INFL and DONE entries, using the line-address compare. If several entries match, the youngest (closest to tail) SHALL win. lkup_data SHALL be 0 on a miss.
REQ-014 Simultaneous events:
- Enqueue, issue, ack and retire in one cycle SHALL all take effect.
- Lookup SHALL reflect pre-update state.
- A full buffer retiring in the same cycle SHALL still deassert enq_ready; the freed slot is not bypassed.
REQ-015 An enqueue that matches only INFL or DONE entries SHALL allocate a new entry; it SHALL NOT coalesce.

Reset
REQ-016 On reset_n low, asynchronously:
- all entries FREE; head = iss = tail = 0.
- wbq2arb_valid = 0, lkup_hit = 0, wbq_empty = 1, wbq_count = 0.
- enq_ready = 1.
REQ-017 Reset mid-operation SHALL discard all PEND and INFL entries. Subsequent acks SHALL be ignored per REQ-011.
REQ-018 Data arrays need not be reset. All data outputs SHALL be 0 whenever their valid or hit is 0.

Verification
REQ-019 Enqueue A = 0x1000 then B = 0x2040, with wbq2arb_ready = 1 -> issues A (wbqid 0) then B (wbqid 1) on consecutive cycles; wbq_count = 2.
REQ-020 Hold wbq2arb_ready = 0 and enqueue 0x1000 twice with data D1 then D2 -> wbq_count = 1; the issued data is D2.
REQ-021 Fill DEPTH = 8 entries -> enq_ready = 0, wbq_count = 8. Ack ids 3 then 0 -> count drops to 7 one cycle after ack 0 only. Ack 1, then 2 -> head retires through entry 3 in consecutive cycles.
REQ-022 Issue 0x3000 (INFL), then enqueue 0x3000 with new data -> a new entry is allocated; lkup_paddr = 0x3010 returns the new data with hit = 1.
REQ-023 Assert reset_n = 0 with 5 entries live -> wbq2arb_valid = 0 and wbq_empty = 1 immediately; an ack for id 2 after release changes nothing.
REQ-024 Wrap test: 20 allocate/ack/retire cycles at DEPTH = 8 -> ids cycle 0..7,0..7,0..3; no loss, duplication or reordering of issues.
